pcie_tx_pkt_arbiter: RTL and testbench

//  Packet-atomic weighted round-robin arbiter that merges NUM_CH AXI-S TX streams onto the single PCIe SS TX port.

---
 rtl/ofs_fim_cfg_pkg.sv | 5 +
 rtl/pcie_ss_axis_pkg.sv | 18 +
 rtl/pcie_ss_axis_if.sv | 14 +
 rtl/pcie_tx_arb_skid_buf.sv | 46 ++++
 rtl/pcie_tx_pkt_arbiter.sv | 124 ++++++++++++
 tb/tb_pcie_tx_pkt_arbiter.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ofs_fim_cfg_pkg.sv
// FIM-wide configuration constants shared by the PCIe host-channel datapath.
package ofs_fim_cfg_pkg;
  localparam int PCIE_TDATA_WIDTH = 512;
  localparam int PCIE_TUSER_WIDTH = 10;
endpackage

// File: rtl/pcie_ss_axis_pkg.sv
// Types shared by the PCIe SS AXI-S TX path: arbiter states and a packed beat record.
package pcie_ss_axis_pkg;
  import ofs_fim_cfg_pkg::*;

  localparam int PCIE_TKEEP_WIDTH = PCIE_TDATA_WIDTH / 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_PKT  = 1'b1
  } t_tx_arb_state;

  typedef struct packed {
    logic [PCIE_TDATA_WIDTH-1:0] tdata;
    logic [PCIE_TKEEP_WIDTH-1:0] tkeep;
    logic                        tlast;
    logic [PCIE_TUSER_WIDTH-1:0] tuser_vendor;
  } t_axis_beat;
endpackage

// File: rtl/pcie_ss_axis_if.sv
// AXI-S bundle toward/from the PCIe subsystem; sink receives beats, source emits them.
interface pcie_ss_axis_if;
  import ofs_fim_cfg_pkg::*;

  logic                          tvalid;
  logic                          tready;
  logic [PCIE_TDATA_WIDTH-1:0]   tdata;
  logic [PCIE_TDATA_WIDTH/8-1:0] tkeep;
  logic                          tlast;
  logic [PCIE_TUSER_WIDTH-1:0]   tuser_vendor;

  modport sink   (input tvalid, tdata, tkeep, tlast, tuser_vendor, output tready);
  modport source (output tvalid, tdata, tkeep, tlast, tuser_vendor, input tready);
endinterface

// File: rtl/pcie_tx_arb_skid_buf.sv
// Two-entry AXI-S register slice; in_ready depends only on local occupancy,
// so the upstream ready path never sees the downstream tready.
module pcie_tx_arb_skid_buf
  import pcie_ss_axis_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  t_axis_beat in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output t_axis_beat out_beat
);

  t_axis_beat mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The head entry is never overwritten while occupied, which keeps the output stable under backpressure.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_beat;
  end

endmodule

// File: rtl/pcie_tx_pkt_arbiter.sv
// Packet-atomic weighted round-robin merge of NUM_CH AXI-S TX streams onto the PCIe SS TX port.
module pcie_tx_pkt_arbiter
  import ofs_fim_cfg_pkg::*;
  import pcie_ss_axis_pkg::*;
#(
  parameter  int NUM_CH   = 2,
  parameter  int WEIGHT_W = 4,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pcie_ss_axis_if.sink                 sink [NUM_CH],
  pcie_ss_axis_if.source               source,
  input  logic [NUM_CH*WEIGHT_W-1:0]   cfg_weight,
  output logic [CH_W-1:0]              arb_grant_ch,
  output logic                         arb_in_pkt
);

  logic [NUM_CH-1:0]   sink_tvalid;
  logic [NUM_CH-1:0]   eligible;
  logic [NUM_CH-1:0]   tready_vec;
  t_axis_beat          sink_beat [NUM_CH];
  logic [WEIGHT_W-1:0] weight    [NUM_CH];

  t_tx_arb_state       state, state_n;
  logic [CH_W-1:0]     last_ch, last_ch_n;
  logic [WEIGHT_W-1:0] quantum_left, quantum_n;
  logic [CH_W-1:0]     sel;
  logic                sel_vld;
  logic                buf_ready;
  logic                accept;
  int                  cand;
  logic [CH_W-1:0]     cand_ch;

  t_axis_beat          out_beat;
  logic                out_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sink_tvalid[i]  = sink[i].tvalid;
    assign sink_beat[i]    = '{tdata:        sink[i].tdata,
                               tkeep:        sink[i].tkeep,
                               tlast:        sink[i].tlast,
                               tuser_vendor: sink[i].tuser_vendor};
    assign weight[i]       = cfg_weight[i*WEIGHT_W +: WEIGHT_W];
    assign eligible[i]     = sink_tvalid[i] && (weight[i] != '0);
    assign sink[i].tready  = tready_vec[i];
  end

  // Mid-packet the grant is locked; otherwise stay on last_ch while its quantum lasts, then rotate.
  always_comb begin
    sel     = last_ch;
    sel_vld = 1'b0;
    cand    = 0;
    cand_ch = '0;
    if (state == ARB_PKT) begin
      sel_vld = 1'b1;
    end else if (eligible[last_ch] && (quantum_left != '0)) begin
      sel_vld = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand    = (int'(last_ch) + k) % NUM_CH;
        cand_ch = CH_W'(cand);
        if (!sel_vld && eligible[cand_ch]) begin
          sel_vld = 1'b1;
          sel     = cand_ch;
        end
      end
    end
  end

  always_comb begin
    tready_vec = '0;
    if (rst_n && sel_vld) tready_vec[sel] = buf_ready;
  end

  assign accept = sink_tvalid[sel] && tready_vec[sel];

  always_comb begin
    state_n   = state;
    last_ch_n = last_ch;
    quantum_n = quantum_left;
    if (accept) begin
      if (state == ARB_IDLE) begin
        last_ch_n = sel;
        if ((sel == last_ch) && (quantum_left != '0)) quantum_n = quantum_left - WEIGHT_W'(1);
        else                                          quantum_n = weight[sel] - WEIGHT_W'(1);
      end
      state_n = sink_beat[sel].tlast ? ARB_IDLE : ARB_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_ch      <= CH_W'(NUM_CH - 1);
      quantum_left <= '0;
    end else begin
      state        <= state_n;
      last_ch      <= last_ch_n;
      quantum_left <= quantum_n;
    end
  end

  assign arb_grant_ch = last_ch;
  assign arb_in_pkt   = (state == ARB_PKT);

  pcie_tx_arb_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_ready  (buf_ready),
    .in_beat   (sink_beat[sel]),
    .out_valid (out_valid),
    .out_ready (source.tready),
    .out_beat  (out_beat)
  );

  assign source.tvalid       = out_valid;
  assign source.tdata        = out_beat.tdata;
  assign source.tkeep        = out_beat.tkeep;
  assign source.tlast        = out_beat.tlast;
  assign source.tuser_vendor = out_beat.tuser_vendor;

endmodule

// File: tb/tb_pcie_tx_pkt_arbiter.sv
// Randomized directed phases for the TX packet arbiter, checked against a turn-based packet model and an output beat queue.
module tb_pcie_tx_pkt_arbiter;
  import ofs_fim_cfg_pkg::*;
  import pcie_ss_axis_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int WEIGHT_W = 4;
  localparam int CH_W     = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcie_ss_axis_if sink_if [NUM_CH] ();
  pcie_ss_axis_if source_if ();

  logic [NUM_CH*WEIGHT_W-1:0] cfg_weight;
  logic [CH_W-1:0]            arb_grant_ch;
  logic                       arb_in_pkt;

  logic [NUM_CH-1:0] s_valid;
  logic [NUM_CH-1:0] s_ready;
  t_axis_beat        s_beat [NUM_CH];
  logic              src_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drv
    assign sink_if[g].tvalid       = s_valid[g];
    assign sink_if[g].tdata        = s_beat[g].tdata;
    assign sink_if[g].tkeep        = s_beat[g].tkeep;
    assign sink_if[g].tlast        = s_beat[g].tlast;
    assign sink_if[g].tuser_vendor = s_beat[g].tuser_vendor;
    assign s_ready[g]              = sink_if[g].tready;
  end
  assign source_if.tready = src_ready;

  pcie_tx_pkt_arbiter #(.NUM_CH(NUM_CH), .WEIGHT_W(WEIGHT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sink         (sink_if),
    .source       (source_if),
    .cfg_weight   (cfg_weight),
    .arb_grant_ch (arb_grant_ch),
    .arb_in_pkt   (arb_in_pkt)
  );

  int pkt_len   [NUM_CH];
  int beat_idx  [NUM_CH];
  int pkt_seq   [NUM_CH];
  int valid_pct [NUM_CH];
  int len_min, len_max, ready_pct;

  // Model: a "turn" is a run of packets from one channel, capped by the weight captured when the turn began.
  t_axis_beat exp_q [$];
  int m_last, m_turn_weight, m_turn_cnt;
  bit m_in_pkt;
  int pick;
  bit acc, pop;

  int checks = 0;
  int errors = 0;

  function automatic int weight_of(int c);
    return int'(cfg_weight[c*WEIGHT_W +: WEIGHT_W]);
  endfunction

  function automatic t_axis_beat make_beat(int ch, int seq, int idx, bit last);
    t_axis_beat b;
    for (int w = 0; w < PCIE_TDATA_WIDTH/32; w++) b.tdata[w*32 +: 32] = $urandom;
    b.tdata[31:0]  = {8'(ch), 16'(seq), 8'(idx)};
    b.tkeep        = last ? {$urandom, $urandom} : '1;
    b.tlast        = last;
    b.tuser_vendor = PCIE_TUSER_WIDTH'($urandom);
    return b;
  endfunction

  task automatic compare(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int c = 0; c < NUM_CH; c++) begin
      if (!s_valid[c] && ($urandom_range(99) < valid_pct[c])) begin
        if (beat_idx[c] == 0) pkt_len[c] = $urandom_range(len_max, len_min);
        s_beat[c]  = make_beat(c, pkt_seq[c], beat_idx[c], beat_idx[c] == pkt_len[c] - 1);
        s_valid[c] = 1'b1;
      end
    end
    src_ready = ($urandom_range(99) < ready_pct);
  endtask

  task automatic checkOutput();
    bit elig [NUM_CH];
    bit pick_vld, room;
    t_axis_beat got;
    for (int c = 0; c < NUM_CH; c++) elig[c] = s_valid[c] && (weight_of(c) != 0);
    pick     = m_last;
    pick_vld = m_in_pkt || (elig[m_last] && (m_turn_cnt < m_turn_weight));
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!pick_vld && elig[(m_last + k) % NUM_CH]) begin
        pick     = (m_last + k) % NUM_CH;
        pick_vld = 1'b1;
      end
    end
    room = exp_q.size() < 2;
    for (int c = 0; c < NUM_CH; c++)
      compare($sformatf("tready_ch%0d", c), 64'(s_ready[c]), 64'(pick_vld && (c == pick) && room));
    compare("src_tvalid", 64'(source_if.tvalid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      got = '{tdata: source_if.tdata, tkeep: source_if.tkeep,
              tlast: source_if.tlast, tuser_vendor: source_if.tuser_vendor};
      checks++;
      assert (got === exp_q[0]) else begin
        errors++;
        $error("[TB] FAIL src_beat: got %h expected %h", got, exp_q[0]);
      end
    end
    compare("grant_ch", 64'(arb_grant_ch), 64'(m_last));
    compare("in_pkt", 64'(arb_in_pkt), 64'(m_in_pkt));
    acc = pick_vld && room && s_valid[pick];
    pop = src_ready && (exp_q.size() != 0);
  endtask

  task automatic update_model();
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(s_beat[pick]);
      if (!m_in_pkt) begin
        if (pick == m_last && m_turn_cnt < m_turn_weight) begin
          m_turn_cnt++;
        end else begin
          m_turn_weight = weight_of(pick);
          m_turn_cnt    = 1;
        end
        m_last = pick;
      end
      m_in_pkt     = !s_beat[pick].tlast;
      s_valid[pick] = 1'b0;
      if (s_beat[pick].tlast) begin
        beat_idx[pick] = 0;
        pkt_seq[pick]++;
      end else begin
        beat_idx[pick]++;
      end
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      update_model();
    end
  endtask

  // Upstream shares rst_n, so the drivers also abandon any partial packet and restart at SOP.
  task automatic do_reset(int n);
    rst_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_valid[c] = 1'b0;
      if (beat_idx[c] != 0) pkt_seq[c]++;
      beat_idx[c] = 0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) compare($sformatf("rst_tready_ch%0d", c), 64'(s_ready[c]), 64'd0);
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    m_last = NUM_CH - 1; m_turn_weight = 0; m_turn_cnt = 0; m_in_pkt = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic set_phase(int w0, int w1, int v0, int v1, int lmin, int lmax, int rdy);
    cfg_weight = {WEIGHT_W'(w1), WEIGHT_W'(w0)};
    valid_pct[0] = v0; valid_pct[1] = v1;
    len_min = lmin; len_max = lmax; ready_pct = rdy;
  endtask

  initial begin
    int guard;
    s_valid = '0; src_ready = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      s_beat[c] = '0; beat_idx[c] = 0; pkt_seq[c] = 0; pkt_len[c] = 1;
    end
    set_phase(1, 1, 100, 100, 3, 3, 100);
    do_reset(3);

    $display("[TB] equal weights, 3-beat packets, saturated");
    run(40);
    $display("[TB] weights 3/1, single-beat packets");
    set_phase(3, 1, 100, 100, 1, 1, 100);
    run(40);
    $display("[TB] 4-beat packets, both channels contending");
    set_phase(1, 1, 100, 100, 4, 4, 100);
    run(30);
    $display("[TB] random sink gaps and source backpressure");
    set_phase(2, 3, 70, 70, 1, 5, 40);
    run(200);
    set_phase(1, 1, 100, 100, 2, 4, 0);
    run(12);

    $display("[TB] ch1 masked, then unmasked mid ch0 packet");
    set_phase(1, 0, 100, 100, 2, 4, 100);
    run(30);
    guard = 0;
    while (!(m_in_pkt && m_last == 0) && guard < 20) begin
      run(1);
      guard++;
    end
    compare("wait_ch0_mid_pkt", 64'(m_in_pkt && m_last == 0), 64'd1);
    cfg_weight[WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(2);
    run(30);

    $display("[TB] reset during beat 2 of a 3-beat packet");
    set_phase(1, 1, 100, 100, 3, 3, 100);
    guard = 0;
    while (!(m_in_pkt && beat_idx[m_last] == 1) && guard < 20) begin
      run(1);
      guard++;
    end
    compare("wait_beat2", 64'(m_in_pkt && beat_idx[m_last] == 1), 64'd1);
    do_reset(1);
    run(20);

    $display("[TB] random weights");
    for (int r = 0; r < 4; r++) begin
      set_phase($urandom_range(15), $urandom_range(15, 1), $urandom_range(100, 30),
                $urandom_range(100, 30), 1, $urandom_range(6, 1), $urandom_range(100, 30));
      run(60);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
